// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Merges ALU and buffered load results onto the register-file write port.
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_alu_valid,
  output logic                       o_alu_ready,
  input  logic [4:0]                 i_alu_rd,
  input  logic [31:0]                i_alu_data,
  input  logic                       i_ld_valid,
  output logic                       o_ld_ready,
  input  logic [4:0]                 i_ld_rd,
  input  logic [31:0]                i_ld_data,
  output logic                       o_wen,
  output logic [4:0]                 o_rd,
  output logic [31:0]                o_din,
  output logic [$clog2(DEPTH):0]     o_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] c_full     = CW'(DEPTH);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [PW-1:0] c_ptr_one  = PW'(1);
  localparam logic [SW-1:0] c_smax     = SW'(STARVE_MAX);
  localparam logic [SW-1:0] c_s_one    = SW'(1);

  logic [36:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_wen;
  logic [4:0]    r_rd;
  logic [31:0]   r_din;

  logic w_nonempty;
  logic w_alu_ready;
  logic w_ld_ready;
  logic w_alu_win;
  logic w_pop;
  logic w_bypass;
  logic w_push;
  logic w_ld_live;
  logic [36:0] w_head;

  assign w_nonempty  = (r_count != '0);
  assign w_ld_ready  = (r_count != c_full);
  assign w_alu_ready = !((r_starve == c_smax) && w_nonempty);
  assign w_alu_win   = i_alu_valid && w_alu_ready && (i_alu_rd != 5'd0);
  // Loads to x0 are handshaken but otherwise vanish.
  assign w_ld_live   = i_ld_valid && w_ld_ready && (i_ld_rd != 5'd0);
  assign w_pop       = !w_alu_win && w_nonempty;
  assign w_bypass    = !w_alu_win && !w_nonempty && w_ld_live;
  assign w_push      = w_ld_live && !w_bypass;
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_ld_rd, i_ld_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_wen    <= 1'b0;
      r_rd     <= '0;
      r_din    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end

      if (!w_nonempty || w_pop) begin
        r_starve <= '0;
      end else if (r_starve != c_smax) begin
        r_starve <= r_starve + c_s_one;
      end

      // rd/din hold when nothing wins so the port only toggles on real writes.
      if (w_alu_win) begin
        r_wen <= 1'b1;
        r_rd  <= i_alu_rd;
        r_din <= i_alu_data;
      end else if (w_pop) begin
        r_wen <= 1'b1;
        r_rd  <= w_head[36:32];
        r_din <= w_head[31:0];
      end else if (w_bypass) begin
        r_wen <= 1'b1;
        r_rd  <= i_ld_rd;
        r_din <= i_ld_data;
      end else begin
        r_wen <= 1'b0;
      end
    end
  end

  assign o_alu_ready = w_alu_ready;
  assign o_ld_ready  = w_ld_ready;
  assign o_wen       = r_wen;
  assign o_rd        = r_rd;
  assign o_din       = r_din;
  assign o_pending   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed scoreboard bench for the write-back arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_data;
  logic        o_wen;
  logic [4:0]  o_rd;
  logic [31:0] o_din;
  logic [1:0]  o_pending;

  int total = 0;
  int bad   = 0;
  int row_n = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
    .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_wen(o_wen), .o_rd(o_rd), .o_din(o_din), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && o_wen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wen", {o_rd, o_din}, 37'h0);
        if ({o_rd, o_din} == 37'h0) begin
          bad++;
          $display("FAIL unexpected_wen: got wen=1 want wen=0");
        end
      end else begin
        chk("write", {o_rd, o_din}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus: inputs, expected ready/pending before the edge,
  // and the write (if any) that the edge must produce.
  task automatic row(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic ear, input logic elr, input logic [1:0] ep,
                     input logic ew, input logic [4:0] erd, input logic [31:0] edat);
    row_n++;
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = adat;
    i_ld_valid  = lv; i_ld_rd  = lrd; i_ld_data  = ldat;
    #1;
    chk($sformatf("alu_ready[%0d]", row_n), {36'h0, o_alu_ready}, {36'h0, ear});
    chk($sformatf("ld_ready[%0d]", row_n),  {36'h0, o_ld_ready},  {36'h0, elr});
    chk($sformatf("pending[%0d]", row_n),   {35'h0, o_pending},   {35'h0, ep});
    if (ew) exp_q.push_back({erd, edat});
    tick();
  endtask

  task automatic idle(input logic [1:0] ep, input logic ew, input logic [4:0] erd, input logic [31:0] edat);
    row(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, ep != 2'd2, ep, ew, erd, edat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_valid  = 1'b0; i_ld_rd  = '0; i_ld_data  = '0;
    #12;
    chk("rst_wen", {36'h0, o_wen}, 37'h0);
    chk("rst_rd_din", {o_rd, o_din}, 37'h0);
    chk("rst_pending", {35'h0, o_pending}, 37'h0);
    chk("rst_readies", {35'h0, o_alu_ready, o_ld_ready}, 37'h3);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU path
    row(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF);
    idle(0, 0, 5'd0, 32'h0);

    // Collision: ALU wins, load buffered then drained
    row(1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 1, 1, 0, 1, 5'd3, 32'd1);
    idle(1, 1, 5'd4, 32'd2);
    idle(0, 0, 5'd0, 32'h0);

    // Fill, back-pressure and starvation pop with DEPTH=2
    row(1, 5'd1, 32'd100, 1, 5'd8,  32'h80, 1, 1, 0, 1, 5'd1, 32'd100);
    row(1, 5'd1, 32'd101, 1, 5'd9,  32'h90, 1, 1, 1, 1, 5'd1, 32'd101);
    row(1, 5'd1, 32'd102, 1, 5'd10, 32'hA0, 1, 0, 2, 1, 5'd1, 32'd102);
    row(1, 5'd1, 32'd103, 1, 5'd10, 32'hA0, 1, 0, 2, 1, 5'd1, 32'd103);
    row(1, 5'd1, 32'd104, 1, 5'd10, 32'hA0, 1, 0, 2, 1, 5'd1, 32'd104);
    row(1, 5'd1, 32'd105, 1, 5'd10, 32'hA0, 0, 0, 2, 1, 5'd8, 32'h80);
    row(1, 5'd1, 32'd105, 1, 5'd10, 32'hA0, 1, 1, 1, 1, 5'd1, 32'd105);
    idle(2, 1, 5'd9,  32'h90);
    idle(1, 1, 5'd10, 32'hA0);
    idle(0, 0, 5'd0, 32'h0);

    // Starvation with a single buffered load
    row(1, 5'd2, 32'd200, 1, 5'd7, 32'h70, 1, 1, 0, 1, 5'd2, 32'd200);
    row(1, 5'd2, 32'd201, 0, 5'd0, 32'h0,  1, 1, 1, 1, 5'd2, 32'd201);
    row(1, 5'd2, 32'd202, 0, 5'd0, 32'h0,  1, 1, 1, 1, 5'd2, 32'd202);
    row(1, 5'd2, 32'd203, 0, 5'd0, 32'h0,  1, 1, 1, 1, 5'd2, 32'd203);
    row(1, 5'd2, 32'd204, 0, 5'd0, 32'h0,  1, 1, 1, 1, 5'd2, 32'd204);
    row(1, 5'd2, 32'd205, 0, 5'd0, 32'h0,  0, 1, 1, 1, 5'd7, 32'h70);
    row(1, 5'd2, 32'd205, 0, 5'd0, 32'h0,  1, 1, 0, 1, 5'd2, 32'd205);
    idle(0, 0, 5'd0, 32'h0);

    // x0 discard, then a lone load takes the bypass
    row(1, 5'd0, 32'd55, 1, 5'd0, 32'd66, 1, 1, 0, 0, 5'd0, 32'h0);
    row(0, 5'd0, 32'h0,  1, 5'd6, 32'h66, 1, 1, 0, 1, 5'd6, 32'h66);
    idle(0, 0, 5'd0, 32'h0);

    // Async reset while two loads are buffered
    row(1, 5'd1, 32'd300, 1, 5'd11, 32'hB0, 1, 1, 0, 1, 5'd1, 32'd300);
    row(1, 5'd1, 32'd301, 1, 5'd12, 32'hC0, 1, 1, 1, 1, 5'd1, 32'd301);
    i_alu_valid = 1'b0; i_ld_valid = 1'b0;
    chk("pre_reset_pending", {35'h0, o_pending}, 37'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wen", {36'h0, o_wen}, 37'h0);
    chk("async_rst_pending", {35'h0, o_pending}, 37'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle(0, 0, 5'd0, 32'h0);
    idle(0, 0, 5'd0, 32'h0);
    row(1, 5'd13, 32'h130, 0, 5'd0, 32'h0, 1, 1, 0, 1, 5'd13, 32'h130);
    idle(0, 0, 5'd0, 32'h0);
    idle(0, 0, 5'd0, 32'h0);

    chk("queue_drained", 37'(exp_q.size()), 37'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that owns the single write port (wen/rd/din) of the 32x32 register file. It merges results from the single-cycle ALU path and the variable-latency load path onto that port. Load results are buffered in a small FIFO when the port is busy. A starvation guard briefly back-pressures the ALU so that buffered loads always drain.

## Interface
- DEPTH, 2: load-result FIFO entries (power of two, >= 2)
- STARVE_MAX, 4: consecutive cycles a non-empty FIFO may go without a pop before the ALU is stalled (>= 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result present this cycle
- alu_ready  output  1  arbiter accepts ALU result this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- ld_valid  input  1  load result present
- ld_ready  output  1  arbiter accepts load result this cycle
- ld_rd  input  5  load destination register
- ld_data  input  32  load result
- wen  output  1  register-file write enable (registered)
- rd  output  5  register-file write address (registered)
- din  output  32  register-file write data (registered)
- pending  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Handshakes: an ALU transfer occurs when alu_valid && alu_ready. A load transfer occurs when ld_valid && ld_ready.
- ld_ready = (pending != DEPTH). It depends on registered state only, so a push is refused when full even if a pop happens in the same cycle.
- alu_ready = !(starve_cnt == STARVE_MAX && pending != 0). It is combinational from state only and does not depend on alu_valid.
- x0 suppression:
  - An accepted transfer with rd == 0 is consumed and discarded.
  - It never produces wen and never enters the FIFO.
- Write selection each cycle, in priority order:
  1. Accepted ALU transfer with alu_rd != 0 is the winner.
  2. Otherwise, if pending != 0, the FIFO head is popped and is the winner.
  3. Otherwise, an accepted load with ld_rd != 0 bypasses the FIFO and is the winner.
- FIFO push: an accepted load with ld_rd != 0 is pushed unless it took the bypass in the same cycle.
  - Simultaneous push and pop (not full) leaves pending unchanged.
  - FIFO order is strictly preserved.
- Pointers wrap modulo DEPTH. pending ranges from 0 to DEPTH.
- Starvation counter starve_cnt:
  - Reset to 0.
  - Cleared whenever pending == 0 or a pop occurs.
  - Otherwise incremented, saturating at STARVE_MAX.
  - When it is at STARVE_MAX, alu_ready drops and the FIFO pops in that cycle, which clears the counter.
- Write registers:
  - Next cycle, wen = 1, rd = winner rd, din = winner data.
  - With no winner, wen = 0 and rd/din hold their previous values.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - wen = 0, rd = 0, din = 0
  - pending = 0, FIFO pointers 0, starve_cnt = 0
  - ld_ready = 1, alu_ready = 1
- Reset asserted mid-operation discards all buffered loads. No wen is produced after reset asserts.
- Latency, from acceptance edge to wen high:
  - ALU: 1 cycle.
  - Bypassed load: 1 cycle.
  - Buffered load: 1 cycle after the cycle it is popped.
- Throughput: at most one register-file write per cycle. Up to one ALU and one load accepted per cycle.
- The ordering guarantee applies only within each source. An ALU write may overtake an older buffered load. Hazard control upstream must not issue same-rd ALU and load results out of order.
- The register file samples wen/rd/din at the next rising edge, so data is visible to readers two edges after acceptance.

## Test plan
- Reset and ALU path:
  - Stimulus: hold rst_n low, release, then drive alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF.
  - Response: all outputs 0 during reset, then one cycle later wen=1, rd=5, din=32'hDEADBEEF.
- Collision and bypass:
  - Stimulus: same cycle ALU (rd=3, data=1) and load (rd=4, data=2), FIFO empty.
  - Response: cycle+1 writes x3=1 with pending=1, cycle+2 writes x4=2 with pending=0.
- Fill and back-pressure (DEPTH=2):
  - Stimulus: continuous ALU writes to rd=1 plus loads to rd=8, 9, 10.
  - Response: rd=8 and rd=9 buffered. ld_ready=0 while pending=2 and before the starvation pop; rd=10 held until the first pop.
- Starvation (STARVE_MAX=4):
  - Stimulus: ALU valid every cycle, one buffered load.
  - Response: alu_ready drops exactly on the 5th cycle of waiting, the load write appears next cycle, then alu_ready returns to 1.
- x0 discard:
  - Stimulus: ALU rd=0 and load rd=0 each accepted.
  - Response: wen stays 0 and pending stays 0.
- Async reset mid-drain:
  - Stimulus: pending=2, assert rst_n between edges.
  - Response: wen=0 and pending=0 immediately. No further writes after release until new input arrives.
